// File: rtl/rmii_pkg.sv
// rmii_pkg: shared state encoding and byte/frame constants for the RMII TX arbiter.
package rmii_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, HOLD = 2'd2} arb_state_e;
    localparam int RMII_BYTE_W = 8;
    localparam int MAX_FRAME_BYTES_DEF = 1536;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority picker; the first requester at or after rr_ptr (wrapping) wins.
module rr_pick #(
    parameter int N_PORTS = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    function automatic logic [IDX_W-1:0] wrap_add(input int base, input int off);
        return IDX_W'((base + off >= N_PORTS) ? base + off - N_PORTS : base + off);
    endfunction
    logic [IDX_W-1:0] p;
    // Walk offsets from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        found = 1'b0;
        idx = rr_ptr;
        p = rr_ptr;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            p = wrap_add(int'(rr_ptr), i);
            if (req[p]) begin
                found = 1'b1;
                idx = p;
            end
        end
    end
endmodule

// File: rtl/rmii_tx_arbiter.sv
// rmii_tx_arbiter: frame-level round-robin share of one RMII_TX across N_PORTS FIFOs.
// Optional watchdog abort on over-long frames is built when ARB_WATCHDOG_EN is defined.
module rmii_tx_arbiter
    import rmii_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W = 2,
    parameter int HOLD_CYC = 2,
    parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
    input  logic                           REF_CLK,
    input  logic                           arst,
    input  logic [N_PORTS-1:0]             fifo_empty,
    input  logic [N_PORTS-1:0]             fifo_aempty,
    input  logic [N_PORTS-1:0]             fifo_EOD_out,
    input  logic [RMII_BYTE_W*N_PORTS-1:0] fifo_dout,
    output logic [N_PORTS-1:0]             fifo_rden,
    input  logic                           tx_fifo_rden,
    output logic [RMII_BYTE_W-1:0]         tx_fifo_dout,
    output logic                           tx_fifo_empty,
    output logic                           tx_fifo_aempty,
    output logic                           tx_fifo_EOD_out,
    output logic                           grant_valid,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           frame_abort
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    arb_state_e state, nxt;
    logic [IDX_W-1:0] rr_ptr, pick_idx, next_ptr;
    logic [HW-1:0] hold_cnt;
    logic [N_PORTS-1:0] req;
    logic pick_found, eod_g, limit;
    logic [RMII_BYTE_W-1:0] port_byte [N_PORTS];

    for (genvar k = 0; k < N_PORTS; k++) begin : g_byte
        assign port_byte[k] = fifo_dout[RMII_BYTE_W*k +: RMII_BYTE_W];
    end

    // Eligible only with at least AEMPTY_CNT bytes buffered, so a short frame cannot underrun.
    assign req = ~fifo_empty & ~fifo_aempty;
    assign eod_g = fifo_EOD_out[grant_idx];
    assign next_ptr = (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    assign grant_valid = (state == GRANT);

    rr_pick #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_pick (
        .req(req),
        .rr_ptr(rr_ptr),
        .found(pick_found),
        .idx(pick_idx)
    );

`ifdef ARB_WATCHDOG_EN
    logic [11:0] byte_cnt;
    logic abort_q;
    assign limit = tx_fifo_rden && (byte_cnt == 12'(MAX_FRAME_BYTES - 1));
    assign frame_abort = abort_q;
    always_ff @(posedge REF_CLK or posedge arst) begin
        if (arst) begin
            byte_cnt <= '0;
            abort_q <= 1'b0;
        end else begin
            byte_cnt <= (state == GRANT) ? byte_cnt + 12'(tx_fifo_rden) : '0;
            abort_q <= (state == GRANT) && limit && !eod_g;
        end
    end
`else
    assign limit = 1'b0;
    assign frame_abort = 1'b0;
`endif

    always_ff @(posedge REF_CLK or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_idx <= '0;
            hold_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && pick_found) grant_idx <= pick_idx;
            if (state == GRANT && nxt == HOLD) begin
                rr_ptr <= next_ptr;
                hold_cnt <= HW'(HOLD_CYC - 1);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = pick_found ? GRANT : IDLE;
            GRANT:   nxt = (eod_g || limit) ? HOLD : GRANT;
            HOLD:    nxt = (hold_cnt == '0) ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    // HOLD keeps data/EOD muxed so RMII_TX can finish the last byte, but masks the flags.
    always_comb begin
        fifo_rden = '0;
        tx_fifo_dout = '0;
        tx_fifo_empty = 1'b1;
        tx_fifo_aempty = 1'b1;
        tx_fifo_EOD_out = 1'b0;
        if (state != IDLE) begin
            tx_fifo_dout = port_byte[grant_idx];
            tx_fifo_EOD_out = eod_g;
        end
        if (state == GRANT) begin
            fifo_rden[grant_idx] = tx_fifo_rden;
            tx_fifo_empty = fifo_empty[grant_idx];
            tx_fifo_aempty = fifo_aempty[grant_idx];
        end
    end
endmodule

// File: tb/tb_rmii_tx_arbiter.sv
// tb_rmii_tx_arbiter: directed checks of grant order, handshake routing, hold gap and reset.
module tb_rmii_tx_arbiter;
`ifdef ARB_WATCHDOG_EN
    localparam int MFB = 16;
`else
    localparam int MFB = 1536;
`endif
    logic REF_CLK = 1'b0;
    logic arst;
    logic [3:0] fifo_empty, fifo_aempty, fifo_EOD_out, fifo_rden;
    logic [31:0] fifo_dout;
    logic tx_fifo_rden, tx_fifo_empty, tx_fifo_aempty, tx_fifo_EOD_out, grant_valid, frame_abort;
    logic [7:0] tx_fifo_dout;
    logic [1:0] grant_idx;
    int checks = 0;
    int errors = 0;

    rmii_tx_arbiter #(.N_PORTS(4), .IDX_W(2), .HOLD_CYC(2), .MAX_FRAME_BYTES(MFB)) dut (
        .REF_CLK(REF_CLK),
        .arst(arst),
        .fifo_empty(fifo_empty),
        .fifo_aempty(fifo_aempty),
        .fifo_EOD_out(fifo_EOD_out),
        .fifo_dout(fifo_dout),
        .fifo_rden(fifo_rden),
        .tx_fifo_rden(tx_fifo_rden),
        .tx_fifo_dout(tx_fifo_dout),
        .tx_fifo_empty(tx_fifo_empty),
        .tx_fifo_aempty(tx_fifo_aempty),
        .tx_fifo_EOD_out(tx_fifo_EOD_out),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .frame_abort(frame_abort)
    );

    always #5 REF_CLK = ~REF_CLK;

    task automatic tick();
        @(posedge REF_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        arst = 1'b1;
        fifo_empty = 4'b0000;
        fifo_aempty = 4'b0000;
        fifo_EOD_out = 4'b0000;
        fifo_dout = 32'hD3C2B1A0;
        tx_fifo_rden = 1'b1;
        tick();
        tick();
        chk("rst_gv", grant_valid, 0);
        chk("rst_rden", fifo_rden, 0);
        chk("rst_empty", tx_fifo_empty, 1);
        chk("rst_aempty", tx_fifo_aempty, 1);
        chk("rst_eod", tx_fifo_EOD_out, 0);
        chk("rst_dout", tx_fifo_dout, 0);
        chk("rst_idx", grant_idx, 0);
        chk("rst_abort", frame_abort, 0);
        tx_fifo_rden = 1'b0;
        arst = 1'b0;
        tick();
        chk("first_gv", grant_valid, 1);
        chk("first_idx", grant_idx, 0);
        chk("first_empty", tx_fifo_empty, 0);
        for (int n = 0; n < 4; n++) begin
            fifo_dout[7:0] = 8'h10 + 8'(n);
            tx_fifo_rden = 1'b1;
            #1;
            chk("pulse_rden_hi", fifo_rden, 4'b0001);
            chk("pulse_dout", tx_fifo_dout, 8'h10 + n);
            tick();
            tx_fifo_rden = 1'b0;
            #1;
            chk("pulse_rden_lo", fifo_rden, 0);
        end
        chk("p0_still_granted", grant_valid, 1);
        fifo_EOD_out = 4'b0001;
        fifo_empty = 4'b0101;
        fifo_aempty = 4'b0101;
        #1;
        chk("p0_eod_out", tx_fifo_EOD_out, 1);
        tick();
        tx_fifo_rden = 1'b1;
        #1;
        chk("hold_gv", grant_valid, 0);
        chk("hold_rden", fifo_rden, 0);
        chk("hold_empty", tx_fifo_empty, 1);
        chk("hold_aempty", tx_fifo_aempty, 1);
        chk("hold_eod", tx_fifo_EOD_out, 1);
        chk("hold_dout", tx_fifo_dout, 8'h13);
        fifo_EOD_out = 4'b0000;
        tick();
        chk("hold2_gv", grant_valid, 0);
        tx_fifo_rden = 1'b0;
        tick();
        chk("idle_gv", grant_valid, 0);
        chk("idle_dout", tx_fifo_dout, 0);
        tick();
        chk("p1_gv", grant_valid, 1);
        chk("p1_idx", grant_idx, 1);
        chk("p1_dout", tx_fifo_dout, 8'hB1);
        fifo_aempty = 4'b0111;
        #1;
        chk("p1_aempty_pass", tx_fifo_aempty, 1);
        tick();
        chk("p1_stable_gv", grant_valid, 1);
        chk("p1_stable_idx", grant_idx, 1);
        fifo_aempty = 4'b0101;
        fifo_EOD_out = 4'b0010;
        tick();
        fifo_EOD_out = 4'b0000;
        tick();
        tick();
        chk("gap_gv", grant_valid, 0);
        tick();
        chk("p3_gv", grant_valid, 1);
        chk("p3_idx", grant_idx, 3);
        fifo_EOD_out = 4'b1000;
        tick();
        fifo_EOD_out = 4'b0000;
        tick();
        tick();
        chk("gap2_gv", grant_valid, 0);
        tick();
        chk("wrap_idx", grant_idx, 1);
        fifo_EOD_out = 4'b0010;
        fifo_empty = 4'b0000;
        fifo_aempty = 4'b0000;
        tick();
        fifo_EOD_out = 4'b0000;
        tick();
        tick();
        tick();
        chk("p2_idx", grant_idx, 2);
        fifo_empty = 4'b0100;
        fifo_aempty = 4'b0100;
        #1;
        chk("underrun_empty", tx_fifo_empty, 1);
        tick();
        tick();
        chk("underrun_gv", grant_valid, 1);
        chk("underrun_idx", grant_idx, 2);
        fifo_empty = 4'b0000;
        fifo_aempty = 4'b0000;
        fifo_EOD_out = 4'b0100;
        #1;
        chk("refill_empty", tx_fifo_empty, 0);
        tick();
        fifo_EOD_out = 4'b0000;
        tick();
        tick();
        tick();
        chk("rr3_idx", grant_idx, 3);
        fifo_EOD_out = 4'b1000;
        tx_fifo_rden = 1'b1;
        #1;
        chk("pre_rst_eod", tx_fifo_EOD_out, 1);
        chk("pre_rst_rden", fifo_rden, 4'b1000);
        arst = 1'b1;
        #1;
        chk("arst_gv", grant_valid, 0);
        chk("arst_rden", fifo_rden, 0);
        chk("arst_empty", tx_fifo_empty, 1);
        chk("arst_aempty", tx_fifo_aempty, 1);
        chk("arst_eod", tx_fifo_EOD_out, 0);
        chk("arst_dout", tx_fifo_dout, 0);
        chk("arst_idx", grant_idx, 0);
        tick();
        arst = 1'b0;
        fifo_EOD_out = 4'b0000;
        tx_fifo_rden = 1'b0;
        tick();
        chk("post_rst_gv", grant_valid, 1);
        chk("post_rst_idx", grant_idx, 0);
`ifdef ARB_WATCHDOG_EN
        tx_fifo_rden = 1'b1;
        repeat (15) tick();
        chk("wd_pre_gv", grant_valid, 1);
        chk("wd_pre_abort", frame_abort, 0);
        tick();
        chk("wd_abort", frame_abort, 1);
        chk("wd_hold_gv", grant_valid, 0);
        tx_fifo_rden = 1'b0;
        tick();
        chk("wd_abort_off", frame_abort, 0);
        tick();
        tick();
        chk("wd_next_gv", grant_valid, 1);
        chk("wd_next_idx", grant_idx, 1);
`else
        tx_fifo_rden = 1'b1;
        repeat (20) tick();
        chk("nowd_abort", frame_abort, 0);
        chk("nowd_gv", grant_valid, 1);
        tx_fifo_rden = 1'b0;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rmii_tx_arbiter.md
Name: rmii_tx_arbiter

Overview:
- Frame-level round-robin scheduler that shares one RMII_TX transmitter between N_PORTS FRAME_FIFO read sides.
- Used in the multi-PHY repeater where every RX port's frames must egress on a common PHY.
- Grants one FIFO per frame and routes the TX read handshake to it.
- Presents the granted FIFO's flags and data to RMII_TX unchanged, holds the grant until end-of-data, then enforces a fixed turnaround before re-arbitrating.

Parameters:
N_PORTS, 4, number of requesting FIFOs (2..8)
IDX_W, 2, width of a port index; must be >= clog2(N_PORTS)
HOLD_CYC, 2, idle cycles between frame end and next grant (>=1)
MAX_FRAME_BYTES, 1536, watchdog byte limit per grant (only with ARB_WATCHDOG_EN)

Ports:
REF_CLK  in  1  RMII 50 MHz reference clock; sole clock
arst  in  1  asynchronous active-high reset
fifo_empty  in  N_PORTS  per-port FIFO empty flag
fifo_aempty  in  N_PORTS  per-port FIFO almost-empty flag
fifo_EOD_out  in  N_PORTS  per-port end-of-data marker accompanying dout
fifo_dout  in  8*N_PORTS  per-port read data; port k occupies bits [8k+7:8k]
fifo_rden  out  N_PORTS  per-port read enable
tx_fifo_rden  in  1  read enable from RMII_TX
tx_fifo_dout  out  8  muxed data to RMII_TX
tx_fifo_empty  out  1  muxed empty to RMII_TX
tx_fifo_aempty  out  1  muxed almost-empty to RMII_TX
tx_fifo_EOD_out  out  1  muxed EOD to RMII_TX
grant_valid  out  1  high in GRANT state
grant_idx  out  IDX_W  index of current or last granted port
frame_abort  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (arst high, asynchronous): state=IDLE, rr_ptr=0, grant_idx=0, hold counter=0, byte counter=0, grant_valid=0, frame_abort=0.
- Reset outputs: fifo_rden=0, tx_fifo_empty=1, tx_fifo_aempty=1, tx_fifo_EOD_out=0, tx_fifo_dout=0.
- Reset asserted mid-frame: same values immediately. No frame resume; the partially read FIFO frame is left to RMII_TX/FIFO recovery.
- Port eligibility: req[k] = ~fifo_empty[k] & ~fifo_aempty[k], i.e. at least AEMPTY_CNT bytes buffered. This guarantees RMII_TX cannot underrun on a minimum-size frame.
- States: IDLE, GRANT, HOLD.
- IDLE:
  - Scan req starting at rr_ptr, wrapping modulo N_PORTS; first eligible port wins.
  - On any req: register grant_idx=winner and enter GRANT next edge. Grant latency is 1 cycle from req.
  - No req: stay in IDLE.
- GRANT:
  - fifo_rden[grant_idx] = tx_fifo_rden (combinational); all other bits 0.
  - tx_fifo_dout, tx_fifo_empty, tx_fifo_aempty and tx_fifo_EOD_out come straight from port grant_idx.
  - Requests on other ports, and the granted port's aempty/empty changes, never change the grant.
  - Granted FIFO going empty before EOD (underrun): stay in GRANT and pass empty=1 through.
  - On an edge where fifo_EOD_out[grant_idx]=1: go to HOLD, set rr_ptr=(grant_idx+1) mod N_PORTS, load hold counter=HOLD_CYC-1.
- HOLD:
  - fifo_rden=0; tx_fifo_empty=1, tx_fifo_aempty=1.
  - tx_fifo_dout and tx_fifo_EOD_out stay muxed from grant_idx so RMII_TX can finish the last byte.
  - Counter decrements each cycle; at 0, go to IDLE.
  - Minimum gap from frame end to next grant: HOLD_CYC + 1 cycles.
- grant_valid = (state==GRANT). grant_idx holds its value through HOLD and IDLE.
- Widths: rr_ptr and grant_idx are IDX_W bits. Wrap is an explicit compare against N_PORTS-1, not a power-of-two overflow.

Optional Feature:
- Macro ARB_WATCHDOG_EN defined:
  - A 12-bit counter clears on entry to GRANT and increments on each tx_fifo_rden in GRANT.
  - If it reaches MAX_FRAME_BYTES with no EOD: pulse frame_abort for 1 cycle, go to HOLD, advance rr_ptr as for a normal frame end.
  - EOD and limit on the same edge: treated as a normal end, no abort.
- Macro not defined: no counter is built and frame_abort is tied 0.

Decomposition:
- Shared package rmii_pkg: state encoding constants (IDLE=2'd0, GRANT=2'd1, HOLD=2'd2), the 8-bit RMII byte width constant, and the default MAX_FRAME_BYTES.
- One sub-module: rr_pick (combinational rotate-priority picker; inputs req and rr_ptr; outputs found and idx).
- The FSM and all muxing live in rmii_tx_arbiter.

Test Plan:
- Reset with all FIFOs full: grant_valid=0, tx_fifo_empty=1, fifo_rden=0. Release reset: grant_idx=0 one cycle later.
- Ports 1 and 3 eligible, rr_ptr=2: port 3 granted; after its EOD, 2 HOLD cycles, then port 1 granted.
- In GRANT on port 0, pulse tx_fifo_rden 4 times: fifo_rden[0] mirrors each pulse exactly; fifo_rden[3:1] stay 0; tx_fifo_dout equals port 0 data.
- Port 2 granted and drains to empty without EOD: tx_fifo_empty=1 and grant holds. Refill with EOD: frame completes and rr_ptr=3.
- Assert arst for 1 cycle mid-GRANT: all outputs return to reset values asynchronously; the next grant starts the scan from port 0.
- With ARB_WATCHDOG_EN and MAX_FRAME_BYTES=16: 16 reads with no EOD give frame_abort=1 for 1 cycle, then HOLD, then the next port is granted.
